seq_bit_serializer: RTL and testbench

//  Upstream feeder for the serial sequence detector. Accepts bytes over a valid/ready

---
 rtl/seq_bit_serializer_if.sv | 18 +
 rtl/seq_bit_serializer.sv | 194 +++++++++++++++++++
 tb/tb_seq_bit_serializer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_bit_serializer_if.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer_if
// Byte handshake between a producer and seq_bit_serializer.
//   in_valid  producer -> serializer : byte offered on in_data
//   in_data   producer -> serializer : 8-bit payload
//   in_last   producer -> serializer : byte closes its frame
//   in_ready  serializer -> producer : FIFO has room for a byte
// master = producer side, slave = serializer side.
// ---------------------------------------------------------------------------
interface seq_bit_serializer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
// Buffers bytes in a small FIFO and emits each frame as a gap-free serial bit
// stream, announced by a one-cycle start pulse. halt aborts the current frame
// and flushes the FIFO.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_bus     slave modport of seq_bit_serializer_if (in_valid/in_data/
//              in_last in, in_ready out; in_ready is combinational from count)
//   halt       in   abort frame, flush FIFO (priority over everything else)
//   start      out  one-cycle pulse, the cycle before the first bit of a frame
//   bit_out    out  serial data bit
//   bit_valid  out  bit_out carries frame data this cycle
//   busy       out  FSM not idle
//   underrun   out  sticky: FIFO ran dry in the middle of a frame
//   frame_cnt  out  completed frames, wraps
//
// Configuration macro:
//   SER_LSB_FIRST_EN  defined   -> bytes serialised LSB first
//                     undefined -> MSB first (default)
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_bit_serializer_if.slave  in_bus,
  input  logic                 halt,
  output logic                 start,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 busy,
  output logic                 underrun,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STALL} state_t;

  // Bit ordering helpers: lead_bit is the bit on the wire next,
  // shift_out drops that bit so the following one becomes the lead.
`ifdef SER_LSB_FIRST_EN
  function automatic logic lead_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] shift_out(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction
`else
  function automatic logic lead_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] shift_out(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction
`endif

  // FIFO storage: {last, data} per entry
  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [8:0]       head;
  logic             push;
  logic             pop;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       cur_last;

  assign in_bus.in_ready = (count != FULL_CNT);
  assign push = in_bus.in_valid & in_bus.in_ready & ~halt;
  assign head = mem[rd_ptr];

  // Pop conditions mirror the FSM's load points so FIFO and FSM stay in step.
  always_comb begin
    pop = 1'b0;
    if (!halt && count != '0) begin
      case (state)
        START:   pop = 1'b1;
        SHIFT:   pop = (bit_cnt == 3'd7) && !cur_last;
        STALL:   pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_bus.in_last, in_bus.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (halt) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // bit_out is registered, so on a load the first bit goes straight to
  // bit_out and shreg keeps the whole byte; each advance presents the
  // lead bit of the shifted register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      cur_last  <= 1'b0;
      start     <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      frame_cnt <= '0;
    end else if (halt) begin
      state     <= IDLE;
      start     <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          start <= 1'b0;
          if (count != '0) begin
            state <= START;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        START: begin
          start     <= 1'b0;
          state     <= SHIFT;
          shreg     <= head[7:0];
          bit_out   <= lead_bit(head[7:0]);
          cur_last  <= head[8];
          bit_cnt   <= 3'd0;
          bit_valid <= 1'b1;
        end
        SHIFT: begin
          if (bit_cnt != 3'd7) begin
            shreg   <= shift_out(shreg);
            bit_out <= lead_bit(shift_out(shreg));
            bit_cnt <= bit_cnt + 3'd1;
          end else if (cur_last) begin
            state     <= IDLE;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end else if (count != '0) begin
            // next byte of the same frame follows with no gap
            shreg    <= head[7:0];
            bit_out  <= lead_bit(head[7:0]);
            cur_last <= head[8];
            bit_cnt  <= 3'd0;
          end else begin
            state     <= STALL;
            bit_valid <= 1'b0;
            underrun  <= 1'b1;
          end
        end
        STALL: begin
          if (count != '0) begin
            state     <= SHIFT;
            shreg     <= head[7:0];
            bit_out   <= lead_bit(head[7:0]);
            cur_last  <= head[8];
            bit_cnt   <= 3'd0;
            bit_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_bit_serializer
// Self-checking bench for seq_bit_serializer. The reference is a plain list of
// expected wire bits built from the bytes pushed, a frame counter and a count
// of expected start pulses; a monitor records every valid bit with its cycle.
// ---------------------------------------------------------------------------
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt = 1'b0;
  logic       start;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;
  logic       underrun;
  logic [7:0] frame_cnt;

  seq_bit_serializer_if bus ();

  seq_bit_serializer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (bus),
    .halt      (halt),
    .start     (start),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .underrun  (underrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_frames = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  logic obs_bits[$];
  int   obs_cyc[$];
  logic exp_bits[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_valid) begin
        obs_bits.push_back(bit_out);
        obs_cyc.push_back(cyc);
      end
      if (start) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
    end
  end

  // Wire order of a byte, straight from the configured bit order.
  function automatic void add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
`ifdef SER_LSB_FIRST_EN
      exp_bits.push_back(b[i]);
`else
      exp_bits.push_back(b[7-i]);
`endif
    end
  endfunction

  task automatic clear_obs();
    @(posedge clk); #1;
    obs_bits.delete();
    obs_cyc.delete();
    exp_bits.delete();
    start_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, output int acc_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      vectors++; miscompares++;
      $display("FAIL push_ready_timeout byte=%h", d);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frames();
    int guard;
    guard = 0;
    while (frame_cnt !== 8'(exp_frames) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (frame_cnt !== 8'(exp_frames)) begin
      miscompares++;
      $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, 8'(exp_frames));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bits(input int n);
    int guard;
    guard = 0;
    @(negedge clk); #1;
    while (obs_bits.size() < n && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    if (obs_bits.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL wait_bits got=%0d want=%0d", obs_bits.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({start, bit_out, bit_valid, busy, underrun, bus.in_ready, frame_cnt} !== {6'b000001, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_hold got=%b want=%b", {start, bit_out, bit_valid, busy, underrun, bus.in_ready, frame_cnt}, {6'b000001, 8'd0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({start, bit_out, bit_valid, busy, underrun, bus.in_ready, frame_cnt} !== {6'b000001, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_release got=%b want=%b", {start, bit_out, bit_valid, busy, underrun, bus.in_ready, frame_cnt}, {6'b000001, 8'd0});
    end
    $display("txn reset done");
  endtask

  task automatic test_single();
    int acc;
    clear_obs();
    add_byte(8'hA5);
    push_byte(8'hA5, 1'b1, acc);
    exp_frames++;
    wait_frames();
    vectors++;
    if (obs_bits.size() != 8) begin
      miscompares++; $display("FAIL single_len got=%0d want=8", obs_bits.size());
    end
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++) begin
      vectors++;
      if (obs_bits[i] !== exp_bits[i]) begin
        miscompares++; $display("FAIL single_bit%0d got=%b want=%b", i, obs_bits[i], exp_bits[i]);
      end
    end
    vectors++;
    if (start_cnt != 1 || last_start_cyc != acc + 1) begin
      miscompares++; $display("FAIL single_start pulses=%0d at=%0d want=1 at=%0d", start_cnt, last_start_cyc, acc + 1);
    end
    vectors++;
    if (obs_cyc.size() == 0 || obs_cyc[0] != acc + 2) begin
      miscompares++; $display("FAIL single_latency first_bit_cyc=%0d want=%0d", (obs_cyc.size() == 0) ? -1 : obs_cyc[0], acc + 2);
    end
    $display("txn single 0xA5 bits=%0d frame_cnt=%0d", obs_bits.size(), frame_cnt);
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_obs();
    add_byte(8'h0F); add_byte(8'hF0); add_byte(8'h5A);
    push_byte(8'h0F, 1'b0, acc);
    push_byte(8'hF0, 1'b1, acc);
    push_byte(8'h5A, 1'b1, acc);
    exp_frames += 2;
    wait_frames();
    vectors++;
    if (obs_bits.size() != 24) begin
      miscompares++; $display("FAIL b2b_len got=%0d want=24", obs_bits.size());
    end
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++) begin
      vectors++;
      if (obs_bits[i] !== exp_bits[i]) begin
        miscompares++; $display("FAIL b2b_bit%0d got=%b want=%b", i, obs_bits[i], exp_bits[i]);
      end
    end
    if (obs_cyc.size() >= 17) begin
      vectors++;
      if (obs_cyc[15] - obs_cyc[0] != 15) begin
        miscompares++; $display("FAIL b2b_gapfree span=%0d want=15", obs_cyc[15] - obs_cyc[0]);
      end
      vectors++;
      if (obs_cyc[16] - obs_cyc[15] != 3) begin
        miscompares++; $display("FAIL b2b_interframe gap=%0d want=3", obs_cyc[16] - obs_cyc[15]);
      end
    end
    vectors++;
    if (start_cnt != 2) begin
      miscompares++; $display("FAIL b2b_starts got=%0d want=2", start_cnt);
    end
    $display("txn back_to_back bits=%0d starts=%0d", obs_bits.size(), start_cnt);
  endtask

  task automatic test_underrun();
    int acc;
    clear_obs();
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++; $display("FAIL underrun_pre got=%b want=0", underrun);
    end
    add_byte(8'h3C); add_byte(8'hC3);
    push_byte(8'h3C, 1'b0, acc);
    wait_bits(8);
    repeat (5) @(negedge clk);
    vectors++;
    if ({underrun, bit_valid, busy} !== 3'b101 || obs_bits.size() != 8) begin
      miscompares++;
      $display("FAIL underrun_stall got=%b bits=%0d want=101 bits=8", {underrun, bit_valid, busy}, obs_bits.size());
    end
    push_byte(8'hC3, 1'b1, acc);
    exp_frames++;
    wait_frames();
    vectors++;
    if (obs_bits.size() != 16) begin
      miscompares++; $display("FAIL underrun_len got=%0d want=16", obs_bits.size());
    end
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++) begin
      vectors++;
      if (obs_bits[i] !== exp_bits[i]) begin
        miscompares++; $display("FAIL underrun_bit%0d got=%b want=%b", i, obs_bits[i], exp_bits[i]);
      end
    end
    $display("txn underrun bits=%0d underrun=%b", obs_bits.size(), underrun);
  endtask

  task automatic test_full();
    int acc;
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      add_byte(b);
      push_byte(b, (i == 4), acc);
    end
    exp_frames++;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_ready got=%b want=0", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.in_last = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_frames();
    vectors++;
    if (obs_bits.size() != 40) begin
      miscompares++; $display("FAIL full_len got=%0d want=40", obs_bits.size());
    end
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++) begin
      vectors++;
      if (obs_bits[i] !== exp_bits[i]) begin
        miscompares++; $display("FAIL full_bit%0d got=%b want=%b", i, obs_bits[i], exp_bits[i]);
      end
    end
    vectors++;
    if (start_cnt != 1) begin
      miscompares++; $display("FAIL full_starts got=%0d want=1", start_cnt);
    end
    $display("txn full bits=%0d starts=%0d", obs_bits.size(), start_cnt);
  endtask

  task automatic test_halt();
    int acc;
    logic [7:0] b;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      add_byte(b);
      push_byte(b, (i == 2), acc);
    end
    wait_bits(3);
    halt = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.in_last = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bit_valid, busy, bus.in_ready} !== 3'b001) begin
      miscompares++; $display("FAIL halt_now got=%b want=001", {bit_valid, busy, bus.in_ready});
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (obs_bits.size() != 3 || start_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_after bits=%0d starts=%0d busy=%b want bits=3 starts=1 busy=0", obs_bits.size(), start_cnt, busy);
    end
    vectors++;
    if (frame_cnt !== 8'(exp_frames)) begin
      miscompares++; $display("FAIL halt_frame_cnt got=%0d want=%0d", frame_cnt, 8'(exp_frames));
    end
    for (int i = 0; i < 3 && i < obs_bits.size(); i++) begin
      vectors++;
      if (obs_bits[i] !== exp_bits[i]) begin
        miscompares++; $display("FAIL halt_bit%0d got=%b want=%b", i, obs_bits[i], exp_bits[i]);
      end
    end
    $display("txn halt bits=%0d starts=%0d", obs_bits.size(), start_cnt);
  endtask

  task automatic test_random();
    int acc;
    int nbytes;
    logic [7:0] b;
    clear_obs();
    for (int f = 0; f < 12; f++) begin
      nbytes = $urandom_range(1, 3);
      for (int k = 0; k < nbytes; k++) begin
        b = 8'($urandom);
        add_byte(b);
        push_byte(b, (k == nbytes - 1), acc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      exp_frames++;
    end
    wait_frames();
    vectors++;
    if (obs_bits.size() != exp_bits.size()) begin
      miscompares++; $display("FAIL rand_len got=%0d want=%0d", obs_bits.size(), exp_bits.size());
    end
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++) begin
      vectors++;
      if (obs_bits[i] !== exp_bits[i]) begin
        miscompares++; $display("FAIL rand_bit%0d got=%b want=%b", i, obs_bits[i], exp_bits[i]);
      end
    end
    vectors++;
    if (start_cnt != 12) begin
      miscompares++; $display("FAIL rand_starts got=%0d want=12", start_cnt);
    end
    $display("txn random frames=12 bits=%0d frame_cnt=%0d", obs_bits.size(), frame_cnt);
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_obs();
    push_byte(8'hA5, 1'b1, acc);
    wait_bits(3);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({start, bit_out, bit_valid, busy, underrun, frame_cnt} !== {5'b00000, 8'd0}) begin
      miscompares++;
      $display("FAIL rstmid_now got=%b want=%b", {start, bit_out, bit_valid, busy, underrun, frame_cnt}, {5'b00000, 8'd0});
    end
    exp_frames = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (obs_bits.size() != 3 || start_cnt != 1 || frame_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_after bits=%0d starts=%0d frame_cnt=%0d ready=%b want 3 1 0 1", obs_bits.size(), start_cnt, frame_cnt, bus.in_ready);
    end
    $display("txn reset_mid bits=%0d frame_cnt=%0d", obs_bits.size(), frame_cnt);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_full();
    test_halt();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
